// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - byte-lane data memory with valid/ready load/store front end
//
// Purpose: MEM-stage data memory. NB = DATA_WIDTH/8 independent byte lanes,
// each DEPTH words deep, with write-first synchronous read. Byte, half, word
// and dword accesses at any byte offset are supported. An access that runs
// past the end of a word takes a second beat on the next word, which wraps
// from the last word back to word 0.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   req_valid/ready  request handshake; a request is taken when both are high
//   req_we           1 = store, 0 = load
//   req_size         0 byte, 1 half, 2 word, 3 dword (dword only when 64-bit)
//   req_unsigned     load zero-extends when 1, sign-extends when 0
//   req_addr         byte address
//   req_wdata        store data, LSB-aligned
//   rsp_valid        one-cycle response pulse, in accept order
//   rsp_rdata        extended load data, 0 for stores, errors and idle cycles
//   rsp_err          illegal size, qualified by rsp_valid

module data_memory_lsu #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LNB   = $clog2(NB);
    localparam int WAW   = ADDRESS_WIDTH - LNB;
    localparam int DEPTH = 1 << WAW;
    // Wide enough to hold off + bytes without overflow (max NB-1 + 8).
    localparam int SW    = LNB + 2;

    typedef logic [NB-1:0][7:0] lanes_t;
    typedef enum logic {S_IDLE, S_SPLIT} state_t;

    // Request decode
    logic [LNB-1:0] off_c;
    logic [WAW-1:0] w0_c;
    logic [SW-1:0]  off_x;
    logic [SW-1:0]  bytes_c;
    logic           illegal_c;
    logic           split_c;

    assign off_c     = req_addr[LNB-1:0];
    assign w0_c      = req_addr[ADDRESS_WIDTH-1:LNB];
    assign off_x     = SW'(off_c);
    assign bytes_c   = SW'(1) << req_size;
    assign illegal_c = bytes_c > SW'(NB);
    assign split_c   = !illegal_c && ((off_x + bytes_c) > SW'(NB));

    // Registered state
    state_t         state_q, state_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           err_q, err_d;
    logic           we_q, we_d;
    logic           uns_q, uns_d;
    logic [1:0]     size_q, size_d;
    logic [LNB-1:0] off_q, off_d;
    logic           split_q, split_d;
    logic [WAW-1:0] w1_q, w1_d;
    lanes_t         wdata_q, wdata_d;
    lanes_t         hold_q, hold_d;
    lanes_t         rd_q, rd_d;

    logic [SW-1:0]  bytes_q;
    logic [SW-1:0]  offq_x;

    assign bytes_q = SW'(1) << size_q;
    assign offq_x  = SW'(off_q);

    // Lane array
    logic [7:0]     lane_mem [NB][DEPTH];
    logic [WAW-1:0] arr_addr;
    logic [NB-1:0]  lane_we;
    lanes_t         lane_wdata;
    lanes_t         wsrc;
    logic [LNB-1:0] cur_off;
    logic           do_read;

    assign req_ready = (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        err_d       = err_q;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        off_d       = off_q;
        split_d     = split_q;
        w1_d        = w1_q;
        wdata_d     = wdata_q;
        hold_d      = hold_q;
        rd_d        = rd_q;
        arr_addr    = w0_c;
        lane_we     = '0;
        lane_wdata  = '0;
        wsrc        = req_wdata;
        cur_off     = off_c;
        do_read     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    uns_d       = req_unsigned;
                    size_d      = req_size;
                    off_d       = off_c;
                    split_d     = split_c;
                    err_d       = illegal_c;
                    w1_d        = w0_c + WAW'(1);
                    wdata_d     = req_wdata;
                    rsp_valid_d = !split_c;
                    do_read     = 1'b1;
                    if (split_c) begin
                        state_d = S_SPLIT;
                    end
                    if (req_we && !illegal_c) begin
                        for (int i = 0; i < NB; i++) begin
                            if ((SW'(i) >= off_x) && (SW'(i) < off_x + bytes_c)) begin
                                lane_we[LNB'(i)] = 1'b1;
                            end
                        end
                    end
                end
            end
            S_SPLIT: begin
                arr_addr    = w1_q;
                wsrc        = wdata_q;
                cur_off     = off_q;
                hold_d      = rd_q;
                rsp_valid_d = 1'b1;
                do_read     = 1'b1;
                state_d     = S_IDLE;
                if (we_q) begin
                    // Lanes 0 .. off+bytes-NB-1 of the next word.
                    for (int i = 0; i < NB; i++) begin
                        if ((SW'(i) + SW'(NB)) < (offq_x + bytes_q)) begin
                            lane_we[LNB'(i)] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset abandons any beat in flight; nothing reaches the array.
        if (!rst_n) begin
            lane_we = '0;
        end

        // Both beats use the same rotation: lane i carries store byte (i - off) mod NB.
        for (int i = 0; i < NB; i++) begin
            lane_wdata[LNB'(i)] = wsrc[LNB'(i) - cur_off];
        end

        if (do_read) begin
            for (int i = 0; i < NB; i++) begin
                rd_d[LNB'(i)] = lane_we[LNB'(i)] ? lane_wdata[LNB'(i)]
                                                 : lane_mem[LNB'(i)][arr_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'd0;
            off_q       <= '0;
            split_q     <= 1'b0;
            w1_q        <= '0;
            wdata_q     <= '0;
            hold_q      <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            off_q       <= off_d;
            split_q     <= split_d;
            w1_q        <= w1_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            rd_q        <= rd_d;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (lane_we[LNB'(i)]) begin
                lane_mem[LNB'(i)][arr_addr] <= lane_wdata[LNB'(i)];
            end
        end
    end

    // Response: gather bytes starting at lane off, first from the first-beat
    // holding register (split only), then from the second word, then extend.
    lanes_t gbyte;
    lanes_t ext;

    always_comb begin : gather
        logic [LNB-1:0] src;
        logic [LNB-1:0] top;
        logic           sign;
        src   = '0;
        top   = '0;
        sign  = 1'b0;
        gbyte = '0;
        ext   = '0;
        for (int i = 0; i < NB; i++) begin
            src = off_q + LNB'(i);
            if (split_q && ((offq_x + SW'(i)) < SW'(NB))) begin
                gbyte[LNB'(i)] = hold_q[src];
            end else begin
                gbyte[LNB'(i)] = rd_q[src];
            end
        end
        top  = LNB'(bytes_q - SW'(1));
        sign = gbyte[top][7] & ~uns_q;
        for (int i = 0; i < NB; i++) begin
            ext[LNB'(i)] = (SW'(i) < bytes_q) ? gbyte[LNB'(i)] : {8{sign}};
        end
        rsp_rdata = (rsp_valid_q && !err_q && !we_q) ? ext : '0;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q & err_q;

endmodule
